// File: rtl/rgb2hsv_seq.sv
// rgb2hsv_seq: valid/ready RGB to value/saturation/hue converter with a built-in sequential divider.
module rgb2hsv_seq #(
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*CW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   value,
    output logic [CW-1:0]   saturation,
    output logic [8:0]      hue,
    output logic            hue_invalid
);
    localparam int NW = CW + 6;

    typedef enum logic [2:0] {IDLE, SORT, DIV, HUE, OUT} state_t;

    state_t         state_q;
    logic [CW-1:0]  r_q, g_q, b_q, delta_q, value_q, sat_q;
    logic [8:0]     base_q, hue_q;
    logic           neg_q, valid_q, inv_q;
    logic [NW-1:0]  rem_q, dsr_q;
    logic [5:0]     quo_q;
    logic [2:0]     cnt_q;

    logic               r_max, g_max, ge;
    logic [CW-1:0]      max_d, min_d, delta_d, absd_d;
    logic signed [CW:0] diff_d;
    logic [NW-1:0]      numer_d;
    logic [8:0]         hbase_d, hraw_d, hue_d;

    // Max selection ties resolve r > g > b so the sector choice is deterministic.
    assign r_max   = (r_q >= g_q) && (r_q >= b_q);
    assign g_max   = !r_max && (g_q >= b_q);
    assign max_d   = r_max ? r_q : g_max ? g_q : b_q;
    assign min_d   = (r_q <= g_q && r_q <= b_q) ? r_q : (g_q <= b_q) ? g_q : b_q;
    assign delta_d = max_d - min_d;
    assign diff_d  = r_max ? $signed({1'b0, g_q}) - $signed({1'b0, b_q})
                   : g_max ? $signed({1'b0, b_q}) - $signed({1'b0, r_q})
                   :         $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    assign absd_d  = diff_d[CW] ? CW'(-diff_d) : diff_d[CW-1:0];
    assign numer_d = ({6'd0, absd_d} << 6) - ({6'd0, absd_d} << 2);
    assign ge      = rem_q >= dsr_q;
    assign hbase_d = (neg_q && base_q == 9'd0) ? 9'd360 : base_q;
    assign hraw_d  = neg_q ? hbase_d - {3'd0, quo_q} : hbase_d + {3'd0, quo_q};
    assign hue_d   = (delta_q == '0 || hraw_d == 9'd360) ? 9'd0 : hraw_d;

    assign in_ready    = state_q == IDLE;
    assign out_valid   = valid_q;
    assign value       = value_q;
    assign saturation  = sat_q;
    assign hue         = hue_q;
    assign hue_invalid = inv_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            delta_q <= '0;
            base_q  <= '0;
            neg_q   <= 1'b0;
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            sat_q   <= '0;
            hue_q   <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    {r_q, g_q, b_q} <= in_data;
                    state_q         <= SORT;
                end
                SORT: begin
                    delta_q <= delta_d;
                    base_q  <= r_max ? 9'd0 : g_max ? 9'd120 : 9'd240;
                    neg_q   <= diff_d[CW];
                    rem_q   <= numer_d;
                    // Divisor starts at delta*32 so six compare/subtract steps yield q MSB first.
                    dsr_q   <= {1'b0, delta_d, 5'd0};
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= (delta_d == '0) ? HUE : DIV;
                end
                DIV: begin
                    if (ge) rem_q <= rem_q - dsr_q;
                    dsr_q   <= dsr_q >> 1;
                    quo_q   <= {quo_q[4:0], ge};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd5) state_q <= HUE;
                end
                HUE: begin
                    value_q <= max_d;
                    sat_q   <= delta_q;
                    hue_q   <= hue_d;
                    inv_q   <= delta_q == '0;
                    valid_q <= 1'b1;
                    state_q <= OUT;
                end
                OUT: if (out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb2hsv_seq.sv
// tb_rgb2hsv_seq: directed checks of rgb2hsv_seq at CW=5 and CW=8 against hand-computed HSV results.
module tb_rgb2hsv_seq;
    logic        clk = 1'b0, res_n = 1'b0;
    logic        iv5 = 1'b0, ir5, ov5, or5 = 1'b1, inv5;
    logic [14:0] id5 = '0;
    logic [4:0]  val5, sat5;
    logic [8:0]  hue5;
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, inv8;
    logic [23:0] id8 = '0;
    logic [7:0]  val8, sat8;
    logic [8:0]  hue8;
    int          n_chk = 0, n_fail = 0;

    rgb2hsv_seq #(.CW(5)) u5 (
        .clk(clk), .res_n(res_n), .in_valid(iv5), .in_ready(ir5), .in_data(id5),
        .out_valid(ov5), .out_ready(or5), .value(val5), .saturation(sat5),
        .hue(hue5), .hue_invalid(inv5)
    );

    rgb2hsv_seq #(.CW(8)) u8 (
        .clk(clk), .res_n(res_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .value(val8), .saturation(sat8),
        .hue(hue8), .hue_invalid(inv8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] px5(input int r, input int g, input int b);
        return {9'd0, 5'(r), 5'(g), 5'(b)};
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic run_px(input bit w8, input logic [23:0] rgb, input int ev, input int es,
                          input int eh, input int ei, input int elat, input string tag);
        int cyc;
        if (w8) begin iv8 = 1'b1; id8 = rgb; end
        else begin iv5 = 1'b1; id5 = rgb[14:0]; end
        for (int i = 0; i < 20 && !(w8 ? ir8 : ir5); i++) @(negedge clk);
        check({tag, "_ready"}, w8 ? ir8 : ir5, 1);
        @(posedge clk);
        @(negedge clk);
        iv5 = 1'b0;
        iv8 = 1'b0;
        cyc = 0;
        while (!(w8 ? ov8 : ov5) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc + 1, elat);
        check({tag, "_val"}, w8 ? 32'(val8) : 32'(val5), ev);
        check({tag, "_sat"}, w8 ? 32'(sat8) : 32'(sat5), es);
        check({tag, "_hue"}, w8 ? hue8 : hue5, eh);
        check({tag, "_inv"}, w8 ? inv8 : inv5, ei);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        bit stable;
        repeat (2) @(negedge clk);
        check("rst_ov", ov5, 0);
        check("rst_val", val5, 0);
        check("rst_sat", sat5, 0);
        check("rst_hue", hue5, 0);
        check("rst_inv", inv5, 0);
        check("rst_ov8", ov8, 0);
        res_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ir5, 1);

        run_px(0, px5(31, 0, 0), 31, 31, 0, 0, 9, "red");
        run_px(0, px5(31, 31, 0), 31, 31, 60, 0, 9, "tie_rg");
        run_px(0, px5(31, 15, 0), 31, 31, 29, 0, 9, "sec_r_pos");
        run_px(0, px5(31, 0, 15), 31, 31, 331, 0, 9, "sec_r_neg");
        run_px(0, px5(0, 20, 10), 20, 20, 150, 0, 9, "sec_g");
        run_px(0, px5(10, 0, 20), 20, 20, 270, 0, 9, "sec_b");
        run_px(0, px5(12, 12, 12), 12, 0, 0, 1, 3, "grey");
        run_px(1, {8'd255, 8'd0, 8'd1}, 255, 255, 0, 0, 9, "wrap8");

        @(negedge clk);
        or5 = 1'b0;
        run_px(0, px5(31, 15, 0), 31, 31, 29, 0, 9, "bp_first");
        iv5 = 1'b1;
        id5 = px5(0, 20, 10)[14:0];
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= ov5 && !ir5 && val5 == 5'd31 && sat5 == 5'd31 && hue5 == 9'd29 && !inv5;
        end
        check("bp_stable", stable, 1);
        or5 = 1'b1;
        @(negedge clk);
        check("bp_ready", ir5, 1);
        check("bp_ov_low", ov5, 0);
        run_px(0, px5(0, 20, 10), 20, 20, 150, 0, 9, "bp_next");

        @(negedge clk);
        iv5 = 1'b1;
        id5 = px5(31, 15, 0)[14:0];
        @(posedge clk);
        @(negedge clk);
        iv5 = 1'b0;
        repeat (3) @(negedge clk);
        res_n = 1'b0;
        #1;
        check("mid_rst_ov", ov5, 0);
        check("mid_rst_val", val5, 0);
        check("mid_rst_sat", sat5, 0);
        check("mid_rst_hue", hue5, 0);
        check("mid_rst_inv", inv5, 0);
        @(negedge clk);
        res_n = 1'b1;
        run_px(0, px5(0, 20, 10), 20, 20, 150, 0, 9, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
